// File: rtl/spi_reg_peripheral_pkg.sv
// spi_reg_pkg: register addresses, frame length and FSM state encoding for the SPI register peripheral
package spi_reg_pkg;
   localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;
   localparam int FRAME_BITS = 16;
   typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;
endpackage

// File: rtl/spi_reg_peripheral_sync_edge.sv
// sync_edge: multi-flop synchroniser for an asynchronous pin with rise/fall pulses on the synced copy
module sync_edge #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] pipe;
   logic prev;
   // shift the pin through the synchroniser and remember the previous synced level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe <= {STAGES{INIT}};
         prev <= INIT;
      end else begin
         pipe <= {pipe[STAGES-2:0], din};
         prev <= pipe[STAGES-1];
      end
   end
   assign sync = pipe[STAGES-1];
   assign rise = sync & ~prev;
   assign fall = ~sync & prev;
endmodule

// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral: write-only SPI mode 0 slave that loads five 8-bit PWM/output control registers
module spi_reg_peripheral
   import spi_reg_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ncs,
   input  logic       sclk,
   input  logic       copi,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe
);
   localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
   state_t state, state_n;
   logic [4:0] bit_cnt;
   logic [15:0] shreg;
   logic [SYNC_STAGES-1:0] flush;
   logic armed;
   logic ncs_s, ncs_rise, ncs_fall;
   logic copi_s;
   logic sclk_rise;
   logic sclk_s_unused, sclk_fall_unused, copi_rise_unused, copi_fall_unused;
   logic [6:0] addr;
   logic [7:0] data;
   logic frame_ok;

   sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ncs (
      .clk(clk), .rst(rst), .din(ncs), .sync(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
      .clk(clk), .rst(rst), .din(sclk), .sync(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
   );
   sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_copi (
      .clk(clk), .rst(rst), .din(copi), .sync(copi_s), .rise(copi_rise_unused), .fall(copi_fall_unused)
   );

   assign addr      = shreg[14:8];
   assign data      = shreg[7:0];
   assign frame_ok  = (bit_cnt == CNT_FULL) && shreg[15] && (addr <= MAX_ADDR);
   assign wr_strobe = (state == COMMIT);

   // only accept a chip-select fall once the ncs synchroniser holds real samples showing ncs high,
   // so a frame already in progress when reset releases is never picked up half-way
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush <= '0;
         armed <= 1'b0;
      end else begin
         flush <= {flush[SYNC_STAGES-2:0], 1'b1};
         armed <= armed | (flush[SYNC_STAGES-1] & ncs_s);
      end
   end

   // next state: ncs rise beats a coincident sclk rise, and only complete valid write frames commit
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = (ncs_fall && armed) ? RECV : IDLE;
         RECV:    state_n = ncs_rise ? (frame_ok ? COMMIT : IDLE) : RECV;
         default: state_n = IDLE;
      endcase
   end

   // state register plus frame shifter; bits past the sixteenth are dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && state_n == RECV) begin
            bit_cnt <= '0;
         end else if (state == RECV && !ncs_rise && sclk_rise && bit_cnt < CNT_FULL) begin
            shreg   <= {shreg[14:0], copi_s};
            bit_cnt <= bit_cnt + 5'd1;
         end
      end
   end

   // register bank: the addressed byte is written during the single COMMIT cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
      end else if (state == COMMIT) begin
         en_reg_out_7_0  <= (addr == ADDR_EN_OUT_LO) ? data : en_reg_out_7_0;
         en_reg_out_15_8 <= (addr == ADDR_EN_OUT_HI) ? data : en_reg_out_15_8;
         en_reg_pwm_7_0  <= (addr == ADDR_EN_PWM_LO) ? data : en_reg_pwm_7_0;
         en_reg_pwm_15_8 <= (addr == ADDR_EN_PWM_HI) ? data : en_reg_pwm_15_8;
         pwm_duty_cycle  <= (addr == ADDR_PWM_DUTY)  ? data : pwm_duty_cycle;
      end
   end
endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb_spi_reg_peripheral: directed SPI frame tests for spi_reg_peripheral
module tb_spi_reg_peripheral;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ncs = 1'b1;
   logic sclk = 1'b0;
   logic copi = 1'b0;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
   logic wr_strobe;
   logic [39:0] regs_v;
   logic [39:0] exp_regs;
   int strobe_cnt = 0;
   int checks = 0;
   int errors = 0;
   int s0;

   spi_reg_peripheral dut (
      .clk(clk), .rst(rst), .ncs(ncs), .sclk(sclk), .copi(copi),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
   );

   assign regs_v = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

   always #5 clk = ~clk;

   // count committed writes, sampled on the falling edge
   always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bits(input logic [31:0] data, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         copi = data[i];
         tick(4);
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
      end
   endtask

   task automatic spi_frame(input logic [31:0] data, input int n, input int gap);
      ncs = 1'b0;
      tick(4);
      spi_bits(data, n);
      tick(4);
      ncs = 1'b1;
      tick(gap);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ncs = 1'($urandom);
         sclk = 1'($urandom);
         copi = 1'($urandom);
         tick(1);
      end
      checks++;
      if (regs_v !== 40'h0) begin
         errors++;
         $display("FAIL reset_regs: got %h expected %h", regs_v, 40'h0);
      end
      checks++;
      if (wr_strobe !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobe: got %b expected 0", wr_strobe);
      end
      ncs = 1'b1;
      sclk = 1'b0;
      copi = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(8);
      exp_regs = 40'h0;
   endtask

   task automatic test_write();
      s0 = strobe_cnt;
      spi_frame(32'h80F0, 16, 8);
      exp_regs[7:0] = 8'hF0;
      checks++;
      if (regs_v !== exp_regs) begin
         errors++;
         $display("FAIL write_addr0: got %h expected %h", regs_v, exp_regs);
      end
      checks++;
      if (strobe_cnt - s0 !== 1) begin
         errors++;
         $display("FAIL write_addr0_strobe: got %0d expected 1", strobe_cnt - s0);
      end
      s0 = strobe_cnt;
      spi_frame(32'h8480, 16, 8);
      exp_regs[39:32] = 8'h80;
      checks++;
      if (regs_v !== exp_regs) begin
         errors++;
         $display("FAIL write_duty: got %h expected %h", regs_v, exp_regs);
      end
      checks++;
      if (strobe_cnt - s0 !== 1) begin
         errors++;
         $display("FAIL write_duty_strobe: got %0d expected 1", strobe_cnt - s0);
      end
   endtask

   task automatic test_rejects();
      logic [31:0] frames [3] = '{32'h00AA, 32'h8555, 32'h0801};
      int lens [3] = '{16, 16, 12};
      for (int k = 0; k < 3; k++) begin
         s0 = strobe_cnt;
         spi_frame(frames[k], lens[k], 8);
         checks++;
         if (regs_v !== exp_regs) begin
            errors++;
            $display("FAIL reject_%0d_regs: got %h expected %h", k, regs_v, exp_regs);
         end
         checks++;
         if (strobe_cnt - s0 !== 0) begin
            errors++;
            $display("FAIL reject_%0d_strobe: got %0d expected 0", k, strobe_cnt - s0);
         end
      end
   endtask

   task automatic test_long_frame();
      s0 = strobe_cnt;
      spi_frame({12'h0, 16'h8233, 4'hA}, 20, 8);
      exp_regs[23:16] = 8'h33;
      checks++;
      if (regs_v !== exp_regs) begin
         errors++;
         $display("FAIL long_frame: got %h expected %h", regs_v, exp_regs);
      end
      checks++;
      if (strobe_cnt - s0 !== 1) begin
         errors++;
         $display("FAIL long_frame_strobe: got %0d expected 1", strobe_cnt - s0);
      end
   endtask

   task automatic test_reset_mid_frame();
      s0 = strobe_cnt;
      ncs = 1'b0;
      tick(4);
      spi_bits(32'h83, 8);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      spi_bits(32'hFF, 8);
      tick(4);
      ncs = 1'b1;
      tick(8);
      exp_regs = 40'h0;
      checks++;
      if (regs_v !== exp_regs) begin
         errors++;
         $display("FAIL rst_mid_frame: got %h expected %h", regs_v, exp_regs);
      end
      checks++;
      if (strobe_cnt - s0 !== 0) begin
         errors++;
         $display("FAIL rst_mid_frame_strobe: got %0d expected 0", strobe_cnt - s0);
      end
      spi_frame(32'h83FF, 16, 8);
      exp_regs[31:24] = 8'hFF;
      checks++;
      if (regs_v !== exp_regs) begin
         errors++;
         $display("FAIL after_rst_write: got %h expected %h", regs_v, exp_regs);
      end
      checks++;
      if (strobe_cnt - s0 !== 1) begin
         errors++;
         $display("FAIL after_rst_strobe: got %0d expected 1", strobe_cnt - s0);
      end
   endtask

   task automatic test_back_to_back();
      s0 = strobe_cnt;
      spi_frame(32'h8155, 16, 2);
      spi_frame(32'h8477, 16, 8);
      exp_regs[15:8] = 8'h55;
      exp_regs[39:32] = 8'h77;
      checks++;
      if (regs_v !== exp_regs) begin
         errors++;
         $display("FAIL back_to_back: got %h expected %h", regs_v, exp_regs);
      end
      checks++;
      if (strobe_cnt - s0 !== 2) begin
         errors++;
         $display("FAIL back_to_back_strobe: got %0d expected 2", strobe_cnt - s0);
      end
   endtask

   task automatic test_latency();
      spi_frame(32'h81C3, 16, 0);
      tick(3);
      checks++;
      if (en_reg_out_15_8 !== 8'h55 || wr_strobe !== 1'b1) begin
         errors++;
         $display("FAIL latency_commit_cycle: got reg %h strobe %b expected reg 55 strobe 1", en_reg_out_15_8, wr_strobe);
      end
      checks++;
      if (regs_v !== exp_regs) begin
         errors++;
         $display("FAIL latency_before: got %h expected %h", regs_v, exp_regs);
      end
      tick(1);
      exp_regs[15:8] = 8'hC3;
      checks++;
      if (regs_v !== exp_regs) begin
         errors++;
         $display("FAIL latency_visible: got %h expected %h", regs_v, exp_regs);
      end
      checks++;
      if (wr_strobe !== 1'b0) begin
         errors++;
         $display("FAIL latency_strobe_end: got %b expected 0", wr_strobe);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_rejects();
      test_long_frame();
      test_reset_mid_frame();
      test_back_to_back();
      test_latency();
      tick(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
